// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase enum, init one-hot indices and default reload values
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_RED    = 2'd2,
        PH_FLASH  = 2'd3
    } phase_t;

    localparam int GREEN_IDX  = 0;
    localparam int YELLOW_IDX = 1;
    localparam int RED_IDX    = 2;

    localparam int DEF_GREEN_T       = 14;
    localparam int DEF_YELLOW_T      = 2;
    localparam int DEF_RED_T         = 17;
    localparam int DEF_PED_MIN_GREEN = 4;

endpackage

// File: rtl/traffic_phase_ctrl_light_counter.sv
// rtl/traffic_phase_ctrl_light_counter.sv - phase countdown with one-hot reload taking priority over decrement
module Light_Counter
    import traffic_pkg::*;
#(
    parameter int pGREEN_INIT_VAL  = DEF_GREEN_T,
    parameter int pYELLOW_INIT_VAL = DEF_YELLOW_T,
    parameter int pRED_INIT_VAL    = DEF_RED_T,
    parameter int pCNT_WIDTH       = $clog2(DEF_RED_T + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2:0]            init,
    output logic [pCNT_WIDTH-1:0] cnt,
    output logic                  last
);

    assign last = (cnt == '0);

    // Reload on init, otherwise count down on en and hold at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= pCNT_WIDTH'(pYELLOW_INIT_VAL);
        end else if (init[RED_IDX]) begin
            cnt <= pCNT_WIDTH'(pRED_INIT_VAL);
        end else if (init[YELLOW_IDX]) begin
            cnt <= pCNT_WIDTH'(pYELLOW_INIT_VAL);
        end else if (init[GREEN_IDX]) begin
            cnt <= pCNT_WIDTH'(pGREEN_INIT_VAL);
        end else if (en && !last) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - intersection phase sequencer with pedestrian cut; optional TLC_NIGHT_FLASH_EN
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_T       = DEF_GREEN_T,
    parameter int YELLOW_T      = DEF_YELLOW_T,
    parameter int RED_T         = DEF_RED_T,
    parameter int CNT_WIDTH     = $clog2(RED_T + 1),
    parameter int PED_MIN_GREEN = DEF_PED_MIN_GREEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 run,
    input  logic                 ped_req,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic                 night_mode,
`endif
    output logic                 lamp_g,
    output logic                 lamp_y,
    output logic                 lamp_r,
    output logic                 ped_walk,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 phase_done
);

    // A pending request may cut GREEN once the count is at or below this value
    localparam logic [CNT_WIDTH-1:0] CUT_AT = CNT_WIDTH'(GREEN_T - PED_MIN_GREEN);

    phase_t         state;
    phase_t         nxt;
    logic           fire;
    logic           adv;
    logic           last;
    logic           en;
    logic [2:0]     init;
    logic           ped_pend;

    assign adv = tick & run;

    // Decide whether a phase boundary fires this cycle and which phase follows
    always_comb begin
        fire = 1'b0;
        nxt  = state;
        case (state)
            PH_YELLOW: if (adv && last) begin
                fire = 1'b1;
                nxt  = PH_RED;
            end
            PH_RED: if (adv && last) begin
                fire = 1'b1;
                nxt  = PH_GREEN;
            end
            PH_GREEN: if (adv && (last || (ped_pend && (cnt_out <= CUT_AT)))) begin
                fire = 1'b1;
                nxt  = PH_YELLOW;
            end
`ifdef TLC_NIGHT_FLASH_EN
            PH_FLASH: if (adv && !night_mode) begin
                fire = 1'b1;
                nxt  = PH_RED;
            end
`endif
            default: begin
                fire = 1'b0;
                nxt  = state;
            end
        endcase
`ifdef TLC_NIGHT_FLASH_EN
        if (fire && (state != PH_FLASH) && night_mode) begin
            nxt = PH_FLASH;
        end
`endif
    end

    // Reload one-hot for the phase being entered; FLASH has no reload
    always_comb begin
        init = 3'b000;
        if (fire) begin
            case (nxt)
                PH_GREEN:  init[GREEN_IDX]  = 1'b1;
                PH_YELLOW: init[YELLOW_IDX] = 1'b1;
                PH_RED:    init[RED_IDX]    = 1'b1;
                default:   init = 3'b000;
            endcase
        end
    end

`ifdef TLC_NIGHT_FLASH_EN
    assign en = adv && (state != PH_FLASH) && (nxt != PH_FLASH);
`else
    assign en = adv;
`endif

    Light_Counter #(
        .pGREEN_INIT_VAL  (GREEN_T),
        .pYELLOW_INIT_VAL (YELLOW_T),
        .pRED_INIT_VAL    (RED_T),
        .pCNT_WIDTH       (CNT_WIDTH)
    ) u_light_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .init  (init),
        .cnt   (cnt_out),
        .last  (last)
    );

    // Phase register, registered lamps, pedestrian latch/walk and boundary pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PH_YELLOW;
            lamp_g     <= 1'b0;
            lamp_y     <= 1'b1;
            lamp_r     <= 1'b0;
            ped_pend   <= 1'b0;
            ped_walk   <= 1'b0;
            phase_done <= 1'b0;
        end else begin
            phase_done <= fire;
            if (fire) begin
                state    <= nxt;
                lamp_g   <= (nxt == PH_GREEN);
                lamp_y   <= (nxt == PH_YELLOW) || (nxt == PH_FLASH);
                lamp_r   <= (nxt == PH_RED);
                ped_walk <= (nxt == PH_RED) ? ped_pend : 1'b0;
            end
`ifdef TLC_NIGHT_FLASH_EN
            else if ((state == PH_FLASH) && adv) begin
                lamp_y <= ~lamp_y;
            end
`endif
            if (fire && (nxt == PH_GREEN)) begin
                ped_pend <= 1'b0;
            end else if (ped_req && (state != PH_RED)) begin
                ped_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - randomized bench against a phase/elapsed-time model with pinned literal checks
module tb_traffic_phase_ctrl;

    localparam int GREEN_T       = 14;
    localparam int YELLOW_T      = 2;
    localparam int RED_T         = 17;
    localparam int PED_MIN_GREEN = 4;
    localparam int CW            = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          tick = 1'b0;
    logic          run = 1'b0;
    logic          ped_req = 1'b0;
    logic          lamp_g, lamp_y, lamp_r, ped_walk, phase_done;
    logic [CW-1:0] cnt_out;

    int tests = 0;
    int fails = 0;
    int n = 0;
    bit chk_en = 1'b0;

    // Model: phase 0=GREEN 1=YELLOW 2=RED, ticks elapsed in phase
    int m_ph = 1;
    int m_el = 0;
    bit m_pend = 1'b0;
    bit m_walk = 1'b0;
    bit m_done = 1'b0;

    traffic_phase_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .run        (run),
        .ped_req    (ped_req),
`ifdef TLC_NIGHT_FLASH_EN
        .night_mode (1'b0),
`endif
        .lamp_g     (lamp_g),
        .lamp_y     (lamp_y),
        .lamp_r     (lamp_r),
        .ped_walk   (ped_walk),
        .cnt_out    (cnt_out),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    function automatic int plen(input int ph);
        if (ph == 0) return GREEN_T + 1;
        if (ph == 1) return YELLOW_T + 1;
        return RED_T + 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at step %0d: got %0d, expected %0d", nm, n, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        bit adv;
        bit go;
        bit np;
        int nph;
        if (!rst_n) begin
            m_ph = 1; m_el = 0; m_pend = 0; m_walk = 0; m_done = 0;
        end else begin
            adv = tick && run;
            go = adv && ((m_el == plen(m_ph) - 1) ||
                         (m_ph == 0 && m_pend && m_el >= PED_MIN_GREEN));
            np = m_pend;
            if (ped_req && m_ph != 2) np = 1;
            if (go) begin
                nph = (m_ph + 1) % 3;
                m_walk = (nph == 2) ? m_pend : 1'b0;
                if (nph == 0) np = 0;
                m_ph = nph;
                m_el = 0;
            end else if (adv) begin
                m_el = m_el + 1;
            end
            m_done = go;
            m_pend = np;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("lamp_g", int'(lamp_g), int'(m_ph == 0));
            chk("lamp_y", int'(lamp_y), int'(m_ph == 1));
            chk("lamp_r", int'(lamp_r), int'(m_ph == 2));
            chk("cnt_out", int'(cnt_out), plen(m_ph) - 1 - m_el);
            chk("ped_walk", int'(ped_walk), int'(m_walk));
            chk("phase_done", int'(phase_done), int'(m_done));
        end
    end

    task automatic cyc(input bit t, input bit r, input bit p);
        tick = t; run = r; ped_req = p;
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_lamp_y", int'(lamp_y), 1);
        chk("rst_cnt", int'(cnt_out), 2);
        chk("rst_done", int'(phase_done), 0);
        rst_n = 1'b1;
        n = 0;

        repeat (3) cyc(1, 1, 0);
        chk("lit_red_entry", int'({lamp_r, phase_done}), 3);
        chk("lit_red_cnt", int'(cnt_out), 17);
        cyc(1, 1, 0);
        chk("lit_done_drop", int'(phase_done), 0);
        repeat (17) cyc(1, 1, 1);
        chk("lit_green_entry", int'({lamp_g, ped_walk}), 2);
        chk("lit_green_cnt", int'(cnt_out), 14);
        repeat (15) cyc(1, 1, 0);
        chk("lit_full_green", int'({lamp_y, cnt_out}), 32 + 2);

        repeat (21) cyc(1, 1, 0);
        cyc(1, 1, 1);
        repeat (4) cyc(1, 1, 0);
        chk("lit_ped_cut", int'({lamp_y, cnt_out}), 32 + 2);
        repeat (3) cyc(1, 1, 0);
        chk("lit_walk_on", int'({lamp_r, ped_walk}), 3);

        repeat (8) cyc(1, 1, 0);
        repeat (5) cyc(1, 0, 0);
        chk("lit_run0_hold", int'(cnt_out), 9);
        cyc(1, 1, 0);
        chk("lit_run_resume", int'(cnt_out), 8);
        repeat (9) cyc(1, 1, 0);
        chk("lit_walk_off", int'({lamp_g, ped_walk}), 2);

        repeat (8) cyc(1, 1, 0);
        cyc(0, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_async_rst", int'({lamp_g, lamp_y, cnt_out}), 32 + 2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(1, 1, 0);
        chk("lit_pend_cleared", int'({lamp_r, ped_walk}), 2);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0,
                $urandom_range(0, 19) == 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
